// File: rtl/wb_serial_tl_bridge_if.sv
// Wishbone classic slave bundle for the serial_tl bridge register window.
interface wb_serial_tl_bridge_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_serial_tl_bridge.sv
// Wishbone register window bridging to ChipTop serial_tl via TX/RX FIFOs.
// Optional internal TX->RX loopback is enabled by defining BRIDGE_LOOPBACK_EN.
module wb_serial_tl_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WIDTH     = 32
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  wb_serial_tl_bridge_if.slave wbs,
  output logic                 tl_in_valid,
  input  logic                 tl_in_ready,
  output logic [WIDTH-1:0]     tl_in_bits,
  input  logic                 tl_out_valid,
  output logic                 tl_out_ready,
  input  logic [WIDTH-1:0]     tl_out_bits,
  output logic                 irq_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] REG_TX     = 2'd0;
  localparam logic [1:0] REG_RX     = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic {ST_IDLE, ST_ACK} state_e;

  state_e            state_q;
  logic              ack_q;
  logic [31:0]       rdat_q;

  logic [WIDTH-1:0]  tx_mem_q [DEPTH];
  logic [WIDTH-1:0]  rx_mem_q [DEPTH];
  logic [PW-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PW-1:0]     rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic              enable_q, irq_en_q, ovf_q, udf_q, irq_q;

  logic              hit, acc;
  logic [1:0]        reg_sel;
  logic              wr_tx, rd_rx, wr_st, wr_ctrl, flush;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              lb_active, lb_move;
  logic [WIDTH-1:0]  rx_wdata;
  logic [31:0]       status, ctrl_rd, rd_mux;
  logic              unused_bits;

  // Address decode: only one access is taken per IDLE->ACK round trip
  assign hit     = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc     = hit & (state_q == ST_IDLE);
  assign reg_sel = wbs.wbs_adr_i[3:2];
  assign wr_tx   = acc &  wbs.wbs_we_i & (reg_sel == REG_TX);
  assign rd_rx   = acc & ~wbs.wbs_we_i & (reg_sel == REG_RX);
  assign wr_st   = acc &  wbs.wbs_we_i & (reg_sel == REG_STATUS);
  assign wr_ctrl = acc &  wbs.wbs_we_i & (reg_sel == REG_CTRL) & wbs.wbs_sel_i[0];
  assign flush   = wr_ctrl & wbs.wbs_dat_i[2];

  assign unused_bits = ^{wbs.wbs_sel_i[3:1], wbs.wbs_adr_i[1:0]};

  assign tx_full  = (tx_cnt_q == CW'(DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

`ifdef BRIDGE_LOOPBACK_EN
  logic lb_q;
  assign lb_active = lb_q;
  assign lb_move   = lb_q & enable_q & ~tx_empty & ~rx_full;
`else
  assign lb_active = 1'b0;
  assign lb_move   = 1'b0;
`endif

  // Serial handshakes derive only from flops, so they follow enable one cycle later
  assign tl_in_valid  = enable_q & ~lb_active & ~tx_empty;
  assign tl_out_ready = enable_q & ~lb_active & ~rx_full;
  assign tl_in_bits   = tx_mem_q[tx_rptr_q];

  assign tx_push  = wr_tx & ~tx_full & ~flush;
  assign tx_pop   = ~flush & ((tl_in_valid & tl_in_ready) | lb_move);
  assign rx_push  = ~flush & ((tl_out_valid & tl_out_ready) | lb_move);
  assign rx_pop   = ~flush & rd_rx & ~rx_empty;
  assign rx_wdata = lb_move ? tx_mem_q[tx_rptr_q] : tl_out_bits;

  always_comb begin : status_word
    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[8:4]   = 5'(tx_cnt_q);
    status[16:12] = 5'(rx_cnt_q);
    status[20]    = ovf_q;
    status[21]    = udf_q;
    ctrl_rd       = {28'd0, lb_active, 1'b0, irq_en_q, enable_q};
  end

  always_comb begin : read_mux
    rd_mux = '0;
    case (reg_sel)
      REG_RX:     rd_mux = rx_empty ? 32'd0 : 32'(rx_mem_q[rx_rptr_q]);
      REG_STATUS: rd_mux = status;
      REG_CTRL:   rd_mux = ctrl_rd;
      default:    rd_mux = '0;
    endcase
  end

  // FIFO pointer/count next state; flush overrides every push and pop
  always_comb begin : fifo_next
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + PW'(1);
      if (tx_pop)  tx_rptr_d = tx_rptr_q + PW'(1);
      if (rx_push) rx_wptr_d = rx_wptr_q + PW'(1);
      if (rx_pop)  rx_rptr_d = rx_rptr_q + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
        2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
        default: tx_cnt_d = tx_cnt_q;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
        2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
        default: rx_cnt_d = rx_cnt_q;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin : fifo_regs
    if (!wb_rst_ni) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counts
  always_ff @(posedge wb_clk_i) begin : fifo_mem
    if (tx_push) tx_mem_q[tx_wptr_q] <= WIDTH'(wbs.wbs_dat_i);
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_wdata;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin : bus_fsm
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            rdat_q  <= wbs.wbs_we_i ? 32'd0 : rd_mux;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          rdat_q  <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          rdat_q  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin : ctrl_regs
    if (!wb_rst_ni) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_q    <= 1'b0;
`ifdef BRIDGE_LOOPBACK_EN
      lb_q     <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) begin
        enable_q <= wbs.wbs_dat_i[0];
        irq_en_q <= wbs.wbs_dat_i[1];
`ifdef BRIDGE_LOOPBACK_EN
        lb_q     <= wbs.wbs_dat_i[3];
`endif
      end
      if (wr_tx && tx_full)                ovf_q <= 1'b1;
      else if (wr_st && wbs.wbs_dat_i[20]) ovf_q <= 1'b0;
      if (rd_rx && rx_empty)               udf_q <= 1'b1;
      else if (wr_st && wbs.wbs_dat_i[21]) udf_q <= 1'b0;
      irq_q <= irq_en_q & (~rx_empty | ovf_q | udf_q);
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = rdat_q;
  assign irq_o         = irq_q;

endmodule
